// File: rtl/cordic_pkg.sv
// Shared constants and types for the vectoring CORDIC engine.
// Angle constants are stored at 30 fractional bits and rescaled to the engine's FRAC_BITS.
package cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int TAB_FRAC = 30;
  localparam int TAB_LEN  = 30;

  localparam logic signed [63:0] PI_HALF     = 64'sh6487ED51;
  localparam real                CORDIC_GAIN = 1.6467602581210657;

  // atan(2^-i) in radians, truncated to 30 fractional bits
  localparam logic signed [63:0] ATAN_TAB [TAB_LEN] = '{
    64'sh3243F6A8, 64'sh1DAC6705, 64'sh0FADBAFC, 64'sh07F56EA6, 64'sh03FEAB76,
    64'sh01FFD55B, 64'sh00FFFAAA, 64'sh007FFF55, 64'sh003FFFEA, 64'sh001FFFFD,
    64'sh000FFFFF, 64'sh0007FFFF, 64'sh0003FFFF, 64'sh0001FFFF, 64'sh0000FFFF,
    64'sh00007FFF, 64'sh00003FFF, 64'sh00001FFF, 64'sh00000FFF, 64'sh000007FF,
    64'sh000003FF, 64'sh000001FF, 64'sh000000FF, 64'sh0000007F, 64'sh0000003F,
    64'sh0000001F, 64'sh0000000F, 64'sh00000007, 64'sh00000003, 64'sh00000001
  };

  function automatic logic signed [63:0] rescale(input logic signed [63:0] v, input int fb);
    if (fb >= TAB_FRAC) return v <<< (fb - TAB_FRAC);
    return v >>> (TAB_FRAC - fb);
  endfunction

  // Beyond the table atan(2^-i) is 2^-i to well below one LSB.
  function automatic logic signed [63:0] atan_q(input int i, input int fb);
    if (i < TAB_LEN) return rescale(ATAN_TAB[i], fb);
    if (i < fb) return 64'sd1 <<< (fb - i);
    return 64'sd0;
  endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// One combinational vectoring micro-rotation: steers y toward zero and
// accumulates the rotated angle into z.
module cordic_vec_stage #(
  parameter int XW = 34,
  parameter int ZW = 33,
  parameter int SW = 4
) (
  input  logic signed [XW-1:0] x_i,
  input  logic signed [XW-1:0] y_i,
  input  logic signed [ZW-1:0] z_i,
  input  logic        [SW-1:0] shift_i,
  input  logic signed [ZW-1:0] atan_i,
  output logic signed [XW-1:0] x_o,
  output logic signed [XW-1:0] y_o,
  output logic signed [ZW-1:0] z_o
);

  logic signed [XW-1:0] x_sh;
  logic signed [XW-1:0] y_sh;

  assign x_sh = x_i >>> shift_i;
  assign y_sh = y_i >>> shift_i;

  always_comb begin
    x_o = x_i;
    y_o = y_i;
    z_o = z_i;
    if (!y_i[XW-1]) begin
      x_o = x_i + y_sh;
      y_o = y_i - x_sh;
      z_o = z_i + atan_i;
    end else begin
      x_o = x_i - y_sh;
      y_o = y_i + x_sh;
      z_o = z_i - atan_i;
    end
  end

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative vectoring CORDIC: returns atan2(y, x) and K*|(x, y)| after
// ITERATIONS clocks, one micro-rotation per clock, valid/ready on both sides.
module cordic_vectoring #(
  parameter int FRAC_BITS  = 30,
  parameter int ITERATIONS = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [FRAC_BITS+1:0]   x_in,
  input  logic [FRAC_BITS+1:0]   y_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [FRAC_BITS+3:0]   mag_out,
  output logic [FRAC_BITS+2:0]   angle_out
);

  import cordic_pkg::*;

  localparam int IW = FRAC_BITS + 2;
  localparam int XW = FRAC_BITS + 4;
  localparam int ZW = FRAC_BITS + 3;
  localparam int CW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
  localparam logic [CW-1:0]        LAST_ITER = CW'(ITERATIONS - 1);
  localparam logic signed [ZW-1:0] PI_HALF_Q = ZW'(rescale(PI_HALF, FRAC_BITS));

  state_e               state_q, state_d;
  logic [CW-1:0]        iter_q, iter_d;
  logic signed [XW-1:0] x_q, x_d, y_q, y_d;
  logic signed [ZW-1:0] z_q, z_d;
  logic                 zero_q, zero_d;
  logic signed [XW-1:0] mag_q, mag_d;
  logic signed [ZW-1:0] angle_q, angle_d;

  logic signed [XW-1:0] x_ext, y_ext, x_ld, y_ld, x_nx, y_nx;
  logic signed [ZW-1:0] z_ld, z_nx;
  logic signed [ZW-1:0] atan_lut [2**CW];

  for (genvar gi = 0; gi < 2**CW; gi++) begin : g_atan
    assign atan_lut[gi] = ZW'(atan_q(gi, FRAC_BITS));
  end

  assign x_ext = {{(XW-IW){x_in[IW-1]}}, x_in};
  assign y_ext = {{(XW-IW){y_in[IW-1]}}, y_in};

  // Fold the left half-plane onto the right so the iterations always converge.
  always_comb begin
    x_ld = x_ext;
    y_ld = y_ext;
    z_ld = '0;
    if (x_ext[XW-1]) begin
      if (!y_ext[XW-1]) begin
        x_ld = y_ext;
        y_ld = -x_ext;
        z_ld = PI_HALF_Q;
      end else begin
        x_ld = -y_ext;
        y_ld = x_ext;
        z_ld = -PI_HALF_Q;
      end
    end
  end

  cordic_vec_stage #(.XW(XW), .ZW(ZW), .SW(CW)) u_stage (
    .x_i     (x_q),
    .y_i     (y_q),
    .z_i     (z_q),
    .shift_i (iter_q),
    .atan_i  (atan_lut[iter_q]),
    .x_o     (x_nx),
    .y_o     (y_nx),
    .z_o     (z_nx)
  );

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    zero_d  = zero_q;
    mag_d   = mag_q;
    angle_d = angle_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          x_d     = x_ld;
          y_d     = y_ld;
          z_d     = z_ld;
          iter_d  = '0;
          zero_d  = (x_in == '0) && (y_in == '0);
          state_d = ST_ITER;
        end
      end
      ST_ITER: begin
        x_d    = x_nx;
        y_d    = y_nx;
        z_d    = z_nx;
        iter_d = iter_q + CW'(1);
        if (iter_q == LAST_ITER) begin
          iter_d  = '0;
          mag_d   = zero_q ? '0 : x_nx;
          angle_d = zero_q ? '0 : z_nx;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      iter_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      zero_q  <= 1'b0;
      mag_q   <= '0;
      angle_q <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      zero_q  <= zero_d;
      mag_q   <= mag_d;
      angle_q <= angle_d;
    end
  end

  // in_ready is gated by rst_n so nothing is offered while reset is held.
  assign in_ready  = rst_n && (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign mag_out   = mag_q;
  assign angle_out = angle_q;

endmodule

// File: tb/tb_cordic_vectoring.sv
// Bench for cordic_vectoring: real-valued atan2/hypot reference, one compare
// process on the falling edge, directed corner vectors plus random vectors.
module tb_cordic_vectoring;

  localparam int  FB   = 30;
  localparam int  ITER = 16;
  localparam int  IW   = FB + 2;
  localparam real SC   = 1073741824.0;
  localparam real TOL  = 1.0 / 16384.0;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid;
  logic signed [FB+1:0] x_in = '0;
  logic signed [FB+1:0] y_in = '0;
  logic signed [FB+3:0] mag_out;
  logic signed [FB+2:0] angle_out;

  cordic_vectoring #(.FRAC_BITS(FB), .ITERATIONS(ITER)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mag_out   (mag_out),
    .angle_out (angle_out)
  );

  always #5 clk = ~clk;

  // Expected results, one entry per accepted vector
  real q_ang[$];
  real q_mag[$];
  bit  q_zero[$];
  bit  q_pin[$];
  real q_pang[$];
  real q_pmag[$];

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  bit  busy = 1'b0;
  int  acc_cyc = 0;
  real gain = 1.0;
  bit  pin_en = 1'b0;
  real pin_ang = 0.0;
  real pin_mag = 0.0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic real absr(input real v);
    return (v < 0.0) ? -v : v;
  endfunction

  task automatic chk(input bit ok, input string name, input real act, input real req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual %0.9f required %0.9f (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk or negedge rst_n) begin : cmp
    real ra, rm, xr, yr;
    bit  prev_valid;
    logic signed [FB+3:0] prev_mag;
    logic signed [FB+2:0] prev_ang;
    #1;
    ra = real'(angle_out) / SC;
    rm = real'(mag_out) / SC;
    if (!rst_n) begin
      chk(out_valid == 1'b0, "reset_out_valid", real'(out_valid), 0.0);
      chk(in_ready == 1'b0, "reset_in_ready", real'(in_ready), 0.0);
      chk(mag_out == '0, "reset_mag", rm, 0.0);
      chk(angle_out == '0, "reset_angle", ra, 0.0);
      q_ang.delete(); q_mag.delete(); q_zero.delete();
      q_pin.delete(); q_pang.delete(); q_pmag.delete();
      busy = 1'b0;
      prev_valid = 1'b0;
    end else begin
      chk(in_ready == !busy, "in_ready", real'(in_ready), real'(!busy));
      chk(out_valid == (busy && (cyc - acc_cyc >= ITER)), "out_valid",
          real'(out_valid), real'(busy && (cyc - acc_cyc >= ITER)));
      if (out_valid && q_ang.size() > 0) begin
        if (q_zero[0]) begin
          chk(mag_out == '0, "zero_mag", rm, 0.0);
          chk(angle_out == '0, "zero_angle", ra, 0.0);
        end else begin
          chk(absr(ra - q_ang[0]) <= TOL, "angle", ra, q_ang[0]);
          chk(absr(rm - q_mag[0]) <= q_mag[0] * TOL, "mag", rm, q_mag[0]);
        end
        if (q_pin[0] && !prev_valid) begin
          chk(absr(ra - q_pang[0]) <= TOL, "pin_angle", ra, q_pang[0]);
          chk(absr(rm - q_pmag[0]) <= q_pmag[0] * TOL, "pin_mag", rm, q_pmag[0]);
        end
        if (prev_valid) begin
          chk(mag_out == prev_mag, "hold_mag", rm, real'(prev_mag) / SC);
          chk(angle_out == prev_ang, "hold_angle", ra, real'(prev_ang) / SC);
        end
      end
      if (out_valid && out_ready) begin
        if (q_ang.size() > 0) begin
          void'(q_ang.pop_front()); void'(q_mag.pop_front()); void'(q_zero.pop_front());
          void'(q_pin.pop_front()); void'(q_pang.pop_front()); void'(q_pmag.pop_front());
        end
        busy = 1'b0;
      end
      if (in_valid && in_ready) begin
        xr = real'(x_in) / SC;
        yr = real'(y_in) / SC;
        q_zero.push_back(xr == 0.0 && yr == 0.0);
        q_ang.push_back((xr == 0.0 && yr == 0.0) ? 0.0 : $atan2(yr, xr));
        q_mag.push_back(gain * $sqrt(xr * xr + yr * yr));
        q_pin.push_back(pin_en);
        q_pang.push_back(pin_ang);
        q_pmag.push_back(pin_mag);
        busy = 1'b1;
        acc_cyc = cyc + 1;
      end
      prev_valid = out_valid;
    end
    prev_mag = mag_out;
    prev_ang = angle_out;
  end

  // All drives happen 1 ns after a rising edge.
  task automatic run_op(input logic signed [FB+1:0] xv, input logic signed [FB+1:0] yv,
                        input int hold, input bit junk, input bit pin, input real pa, input real pm);
    int n;
    pin_en = pin; pin_ang = pa; pin_mag = pm;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    in_valid = 1'b1; x_in = xv; y_in = yv;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    for (int k = 0; k < hold; k++) begin
      if (junk) begin
        in_valid = 1'b1;
        x_in = 32'sh1234_5678;
        y_in = -32'sh0765_4321;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic reset_mid_op(input logic signed [FB+1:0] xv, input logic signed [FB+1:0] yv);
    int n;
    pin_en = 1'b0;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    in_valid = 1'b1; x_in = xv; y_in = yv;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    longint a, b;
    for (int i = 0; i < ITER; i++) gain = gain * $sqrt(1.0 + 2.0 ** (-2.0 * i));

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(32'sh4000_0000, 32'sh0, 0, 1'b0, 1'b1, 0.0, 1.646760);
    run_op(32'sh0, 32'sh4000_0000, 0, 1'b0, 1'b1, 1686629713.0 / SC, 1.646760);
    run_op(-32'sh4000_0000, 32'sh0, 0, 1'b0, 1'b1, 3373259426.0 / SC, 1.646760);
    run_op(32'sh0, -32'sh4000_0000, 1, 1'b0, 1'b1, -1686629713.0 / SC, 1.646760);
    run_op(32'sh2000_0000, 32'sh2000_0000, 2, 1'b0, 1'b1, 843314856.0 / SC, 1.164430);
    run_op(-32'sh4000_0000, -32'sh4000_0000, 0, 1'b0, 1'b1, -2.356194, 2.328871);
    run_op(32'sh0, 32'sh0, 0, 1'b0, 1'b0, 0.0, 0.0);
    run_op(32'sh3000_0000, -32'sh1000_0000, 10, 1'b1, 1'b0, 0.0, 0.0);

    reset_mid_op(32'sh1800_0000, 32'sh2800_0000);
    run_op(32'sh2000_0000, 32'sh2000_0000, 0, 1'b0, 1'b1, 843314856.0 / SC, 1.164430);

    for (int r = 0; r < 60; r++) begin
      do begin
        a = longint'($urandom_range(32'h8000_0000, 0)) - 64'sd1073741824;
        b = longint'($urandom_range(32'h8000_0000, 0)) - 64'sd1073741824;
        if (r % 10 == 0) b = 0;
        if (r % 10 == 5) a = 0;
      end while (((a < 0) ? -a : a) < 64'sd67108864 && ((b < 0) ? -b : b) < 64'sd67108864);
      run_op(IW'(a), IW'(b), int'($urandom_range(3, 0)), r[0], 1'b0, 0.0, 0.0);
    end

    repeat (3) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
